// File: rtl/hog_bridge_pkg.sv
// Shared constants for the HPS bridge responder: register map, bit positions
// inside CTRL / STATUS / IRQ_STATUS, and the bus handshake state encoding.
package hog_bridge_pkg;

  // Word addresses of the bridge register file
  localparam int REG_CTRL       = 0;
  localparam int REG_STATUS     = 1;
  localparam int REG_PIXEL_IN   = 2;
  localparam int REG_RESULT     = 3;
  localparam int REG_IRQ_THRESH = 4;
  localparam int REG_IRQ_STATUS = 5;
  localparam int REG_SCRATCH    = 6;

  // CTRL bits
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_FIFO_CLEAR = 2;

  // STATUS bits
  localparam int STATUS_PIX_VALID = 0;
  localparam int STATUS_EMPTY     = 1;
  localparam int STATUS_FULL      = 2;
  localparam int STATUS_OVERFLOW  = 3;
  localparam int STATUS_LEVEL_LSB = 8;

  // IRQ_STATUS bits
  localparam int IRQ_THRESH_HIT = 0;
  localparam int IRQ_OVERFLOW   = 1;

  // IRQ_THRESH field width (covers 0..FIFO_DEPTH for a 16-entry FIFO)
  localparam int THRESH_WIDTH = 5;

  // Bus handshake states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_RELEASE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering HOG descriptor words. The level counter is kept
// separately from the wrapping pointers so full/empty need no extra flag.
// A pop on an empty FIFO is ignored; a push on a full FIFO only lands when a
// pop frees the head slot in the same cycle. Clear beats everything.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == '0);
  assign level     = level_r;
  assign data_out  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty & ~clear;
  assign do_push_s = push & (~full | do_pop_s) & ~clear;

  // Storage array write port (contents need no reset; level gates visibility)
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointer and level bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/hog_bridge_responder.sv
// Responder for the HPS bridge: decodes accesses into a small register file,
// forwards written pixels to the HOG over valid/ready, and buffers HOG
// descriptor words in a FIFO that the HPS drains by reading RESULT.
module hog_bridge_responder
  import hog_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int BUS_WIDTH  = 32,
  parameter int BUS_BYTES  = BUS_WIDTH / 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  bus_enable,
  input  logic                  r_wbar,
  input  logic [BUS_BYTES-1:0]  byte_enable,
  input  logic [BUS_WIDTH-1:0]  write_data,
  output logic [BUS_WIDTH-1:0]  read_data,
  output logic                  ack,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  input  logic [BUS_WIDTH-1:0]  res_data,
  input  logic                  res_valid,
  output logic                  hog_enable
);

  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

  // Expand byte lanes into a bit mask for masked register writes
  function automatic logic [BUS_WIDTH-1:0] be_mask(input logic [BUS_BYTES-1:0] be);
    logic [BUS_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  bus_state_e              state_r, state_nxt_s;
  logic                    is_ctrl_s, is_status_s, is_pixel_s, is_result_s;
  logic                    is_thresh_s, is_irq_status_s, is_scratch_s;
  logic                    stall_s, access_s, wr_s, rd_s;
  logic [BUS_WIDTH-1:0]    wmask_s, rd_mux_s, status_s;
  logic [1:0]              ctrl_r, irq_stat_r, w1c_s;
  logic [THRESH_WIDTH-1:0] thresh_r;
  logic [BUS_WIDTH-1:0]    scratch_r, rd_data_r;
  logic [DATA_WIDTH-1:0]   pix_r;
  logic                    pix_valid_r, ovf_r, ack_r, irq_r;
  logic                    fifo_pop_s, fifo_clear_s, ovf_evt_s, thr_hit_s;
  logic [BUS_WIDTH-1:0]    fifo_dout_s;
  logic [LEVEL_WIDTH-1:0]  fifo_level_s;
  logic                    fifo_full_s, fifo_empty_s;

  assign is_ctrl_s       = (addr == ADDR_WIDTH'(REG_CTRL));
  assign is_status_s     = (addr == ADDR_WIDTH'(REG_STATUS));
  assign is_pixel_s      = (addr == ADDR_WIDTH'(REG_PIXEL_IN));
  assign is_result_s     = (addr == ADDR_WIDTH'(REG_RESULT));
  assign is_thresh_s     = (addr == ADDR_WIDTH'(REG_IRQ_THRESH));
  assign is_irq_status_s = (addr == ADDR_WIDTH'(REG_IRQ_STATUS));
  assign is_scratch_s    = (addr == ADDR_WIDTH'(REG_SCRATCH));

  // A pixel write must wait while the previous pixel is still unconsumed
  assign stall_s      = is_pixel_s & ~r_wbar & pix_valid_r & ~pixel_ready;
  assign access_s     = (state_r == S_IDLE) & bus_enable & ~stall_s;
  assign wr_s         = access_s & ~r_wbar;
  assign rd_s         = access_s & r_wbar;
  assign wmask_s      = be_mask(byte_enable);
  assign fifo_pop_s   = rd_s & is_result_s;
  assign fifo_clear_s = wr_s & is_ctrl_s & wmask_s[CTRL_FIFO_CLEAR] & write_data[CTRL_FIFO_CLEAR];
  assign ovf_evt_s    = res_valid & fifo_full_s & ~fifo_pop_s & ~fifo_clear_s;
  assign thr_hit_s    = (thresh_r != '0) && (int'(fifo_level_s) >= int'(thresh_r));
  assign w1c_s        = write_data[1:0] & wmask_s[1:0] & {2{wr_s & is_irq_status_s}};

  sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (res_valid),
    .pop      (fifo_pop_s),
    .clear    (fifo_clear_s),
    .data_in  (res_data),
    .data_out (fifo_dout_s),
    .level    (fifo_level_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Bus handshake state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next state: one ack per request, then wait for the initiator to let go
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:    if (access_s)   state_nxt_s = S_ACK;     else state_nxt_s = S_IDLE;
      S_ACK:     if (bus_enable) state_nxt_s = S_RELEASE; else state_nxt_s = S_IDLE;
      S_RELEASE: if (bus_enable) state_nxt_s = S_RELEASE; else state_nxt_s = S_IDLE;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // Read data multiplexer; unmapped and write-only addresses read as zero
  always_comb begin
    status_s = '0;
    status_s[STATUS_PIX_VALID] = pix_valid_r;
    status_s[STATUS_EMPTY]     = fifo_empty_s;
    status_s[STATUS_FULL]      = fifo_full_s;
    status_s[STATUS_OVERFLOW]  = ovf_r;
    status_s[STATUS_LEVEL_LSB +: LEVEL_WIDTH] = fifo_level_s;
    rd_mux_s = '0;
    case (addr)
      ADDR_WIDTH'(REG_CTRL):       rd_mux_s[1:0] = ctrl_r;
      ADDR_WIDTH'(REG_STATUS):     rd_mux_s = status_s;
      ADDR_WIDTH'(REG_RESULT):     if (!fifo_empty_s) rd_mux_s = fifo_dout_s; else rd_mux_s = '0;
      ADDR_WIDTH'(REG_IRQ_THRESH): rd_mux_s[THRESH_WIDTH-1:0] = thresh_r;
      ADDR_WIDTH'(REG_IRQ_STATUS): rd_mux_s[1:0] = irq_stat_r;
      ADDR_WIDTH'(REG_SCRATCH):    rd_mux_s = scratch_r;
      default:                     rd_mux_s = '0;
    endcase
  end

  // Register file, pixel slot and overflow/interrupt status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r      <= '0;
      thresh_r    <= '0;
      scratch_r   <= '0;
      irq_stat_r  <= '0;
      pix_r       <= '0;
      pix_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (wr_s && is_ctrl_s)
        ctrl_r <= (ctrl_r & ~wmask_s[1:0]) | (write_data[1:0] & wmask_s[1:0]);
      if (wr_s && is_thresh_s)
        thresh_r <= (thresh_r & ~wmask_s[THRESH_WIDTH-1:0])
                  | (write_data[THRESH_WIDTH-1:0] & wmask_s[THRESH_WIDTH-1:0]);
      if (wr_s && is_scratch_s)
        scratch_r <= (scratch_r & ~wmask_s) | (write_data & wmask_s);
      // Set wins over a same-cycle W1C so a persisting condition re-asserts
      irq_stat_r[IRQ_THRESH_HIT] <= thr_hit_s | (irq_stat_r[IRQ_THRESH_HIT] & ~w1c_s[IRQ_THRESH_HIT]);
      irq_stat_r[IRQ_OVERFLOW]   <= ovf_evt_s | (irq_stat_r[IRQ_OVERFLOW] & ~w1c_s[IRQ_OVERFLOW]);
      if (fifo_clear_s)   ovf_r <= 1'b0;
      else if (ovf_evt_s) ovf_r <= 1'b1;
      if (wr_s && is_pixel_s && byte_enable[0]) begin
        pix_r       <= write_data[DATA_WIDTH-1:0];
        pix_valid_r <= 1'b1;
      end else if (pix_valid_r && pixel_ready) begin
        pix_valid_r <= 1'b0;
      end
    end
  end

  // Registered bus outputs and interrupt line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r     <= 1'b0;
      rd_data_r <= '0;
      irq_r     <= 1'b0;
    end else begin
      ack_r     <= access_s;
      rd_data_r <= rd_s ? rd_mux_s : '0;
      irq_r     <= ctrl_r[CTRL_IRQ_EN] & (|irq_stat_r);
    end
  end

  assign read_data   = rd_data_r;
  assign ack         = ack_r;
  assign irq         = irq_r;
  assign pixel_out   = pix_r;
  assign pixel_valid = pix_valid_r;
  assign hog_enable  = ctrl_r[CTRL_ENABLE];

endmodule

// File: tb/tb_hog_bridge_responder.sv
// Directed bench for hog_bridge_responder: each task drives one feature and
// checks hand-computed values inline.
module tb_hog_bridge_responder;

  logic        clk;
  logic        rst;
  logic [4:0]  addr;
  logic        bus_enable;
  logic        r_wbar;
  logic [3:0]  byte_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ack;
  logic        irq;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        hog_enable;

  int vectors;
  int miscompares;

  hog_bridge_responder dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .bus_enable  (bus_enable),
    .r_wbar      (r_wbar),
    .byte_enable (byte_enable),
    .write_data  (write_data),
    .read_data   (read_data),
    .ack         (ack),
    .irq         (irq),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .hog_enable  (hog_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bridge access; lat = cycles to ack (0 if none within the bound)
  task automatic bus_xfer(input logic [4:0] a, input logic rw, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
    addr = a; r_wbar = rw; byte_enable = be; write_data = wd; bus_enable = 1'b1;
    lat = 0; rd = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; rd = read_data; break; end
    end
    bus_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    res_data = d; res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    vectors++;
    if ({ack, irq, pixel_valid, hog_enable, pixel_out, read_data} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {ack, irq, pixel_valid, hog_enable, pixel_out, read_data});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0000_0002) begin miscompares++; $display("FAIL reset_status: got %h expected 00000002", rd); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; int lat; int acks;
    bus_xfer(5'd0, 1'b0, 4'hF, 32'h3, rd, lat);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL ctrl_latency: got %0d expected 1", lat); end
    vectors++;
    if (hog_enable !== 1'b1) begin miscompares++; $display("FAIL hog_enable: got %b expected 1", hog_enable); end
    bus_xfer(5'd0, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h3) begin miscompares++; $display("FAIL ctrl_read: got %h expected 00000003", rd); end
    // hold the request 3 cycles past the ack
    addr = 5'd0; r_wbar = 1'b1; bus_enable = 1'b1; acks = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ack) acks++; end
    bus_enable = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (acks !== 1) begin miscompares++; $display("FAIL held_request_acks: got %0d expected 1", acks); end
  endtask

  task automatic test_pixel();
    logic [31:0] rd; int lat; int acks;
    pixel_ready = 1'b0;
    bus_xfer(5'd2, 1'b0, 4'h1, 32'h0000_00A5, rd, lat);
    vectors++;
    if ({pixel_valid, pixel_out} !== 9'h1A5) begin
      miscompares++; $display("FAIL pixel_load: got %h expected 1a5", {pixel_valid, pixel_out});
    end
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0000_0003) begin miscompares++; $display("FAIL status_pixvalid: got %h expected 00000003", rd); end
    // second write must stall while the first pixel is pending
    addr = 5'd2; r_wbar = 1'b0; byte_enable = 4'h1; write_data = 32'h0000_005A; bus_enable = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (ack) acks++; end
    vectors++;
    if ({acks[7:0], pixel_out} !== 16'h00A5) begin
      miscompares++; $display("FAIL pixel_stall: got acks %0d pix %h expected 0 a5", acks, pixel_out);
    end
    pixel_ready = 1'b1; lat = 0;
    for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; if (ack) begin lat = i; break; end end
    vectors++;
    if ({lat[7:0], pixel_valid, pixel_out} !== {8'd1, 1'b1, 8'h5A}) begin
      miscompares++; $display("FAIL pixel_release: got lat %0d v %b pix %h expected 1 1 5a", lat, pixel_valid, pixel_out);
    end
    bus_enable = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL pixel_consumed: got %b expected 0", pixel_valid); end
    pixel_ready = 1'b0;
    bus_xfer(5'd2, 1'b0, 4'hE, 32'h0000_0077, rd, lat);
    vectors++;
    if ({lat[7:0], pixel_valid, pixel_out} !== {8'd1, 1'b0, 8'h5A}) begin
      miscompares++; $display("FAIL pixel_no_lane0: got lat %0d v %b pix %h expected 1 0 5a", lat, pixel_valid, pixel_out);
    end
  endtask

  task automatic test_fifo();
    logic [31:0] rd; int lat;
    logic [31:0] exp_words [3];
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
    for (int i = 0; i < 3; i++) push_word(exp_words[i]);
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0000_0300) begin miscompares++; $display("FAIL fifo_level3: got %h expected 00000300", rd); end
    for (int i = 0; i < 3; i++) begin
      bus_xfer(5'd3, 1'b1, 4'hF, 32'h0, rd, lat);
      vectors++;
      if (rd !== exp_words[i]) begin miscompares++; $display("FAIL fifo_pop%0d: got %h expected %h", i, rd, exp_words[i]); end
    end
    bus_xfer(5'd3, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL fifo_empty_read: got %h expected 0", rd); end
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0000_0002) begin miscompares++; $display("FAIL fifo_empty_status: got %h expected 00000002", rd); end
  endtask

  task automatic test_irq_threshold();
    logic [31:0] rd; int lat;
    bus_xfer(5'd4, 1'b0, 4'hF, 32'h4, rd, lat);
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    @(posedge clk); #1; @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_threshold: got %b expected 1", irq); end
    bus_xfer(5'd5, 1'b0, 4'hF, 32'h1, rd, lat);
    @(posedge clk); #1; @(posedge clk); #1;
    bus_xfer(5'd5, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if ({irq, rd} !== {1'b1, 32'h1}) begin miscompares++; $display("FAIL irq_reassert: got irq %b stat %h expected 1 00000001", irq, rd); end
    bus_xfer(5'd3, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h1) begin miscompares++; $display("FAIL irq_pop: got %h expected 00000001", rd); end
    bus_xfer(5'd5, 1'b0, 4'hF, 32'h1, rd, lat);
    @(posedge clk); #1; @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    bus_xfer(5'd4, 1'b0, 4'hF, 32'h0, rd, lat);
    bus_xfer(5'd0, 1'b0, 4'hF, 32'h7, rd, lat);
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0000_0002) begin miscompares++; $display("FAIL fifo_clear_status: got %h expected 00000002", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd; int lat; int bad;
    for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0000_100C) begin miscompares++; $display("FAIL ovf_status: got %h expected 0000100c", rd); end
    bus_xfer(5'd5, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if ({irq, rd} !== {1'b1, 32'h2}) begin miscompares++; $display("FAIL ovf_irq_status: got irq %b stat %h expected 1 00000002", irq, rd); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus_xfer(5'd3, 1'b1, 4'hF, 32'h0, rd, lat);
      if (rd !== 32'h100 + 32'(i)) bad++;
    end
    bus_xfer(5'd3, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if ({bad[7:0], rd} !== 40'h0) begin miscompares++; $display("FAIL ovf_drain: got %0d bad words, 17th %h expected 0 0", bad, rd); end
    push_word(32'hAA); push_word(32'hBB);
    bus_xfer(5'd0, 1'b0, 4'h1, 32'h7, rd, lat);
    bus_xfer(5'd5, 1'b0, 4'hF, 32'h2, rd, lat);
    bus_xfer(5'd1, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if ({irq, rd} !== {1'b0, 32'h2}) begin miscompares++; $display("FAIL ovf_clear: got irq %b status %h expected 0 00000002", irq, rd); end
  endtask

  task automatic test_scratch_unmapped();
    logic [31:0] rd; int lat;
    bus_xfer(5'd6, 1'b0, 4'b0101, 32'hDEAD_BEEF, rd, lat);
    bus_xfer(5'd6, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h00AD_00EF) begin miscompares++; $display("FAIL scratch_be: got %h expected 00ad00ef", rd); end
    bus_xfer(5'h1F, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if ({lat[7:0], rd} !== {8'd1, 32'h0}) begin miscompares++; $display("FAIL unmapped: got lat %0d data %h expected 1 0", lat, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat;
    addr = 5'd6; r_wbar = 1'b1; byte_enable = 4'hF; bus_enable = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({ack, read_data} !== {1'b1, 32'h00AD_00EF}) begin miscompares++; $display("FAIL pre_reset_ack: got %b %h expected 1 00ad00ef", ack, read_data); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ack, irq, pixel_valid, hog_enable, pixel_out, read_data} !== 44'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0", {ack, irq, pixel_valid, hog_enable, pixel_out, read_data});
    end
    bus_enable = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    bus_xfer(5'd6, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL scratch_after_reset: got %h expected 0", rd); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; addr = 5'd0; bus_enable = 1'b0; r_wbar = 1'b0; byte_enable = 4'h0;
    write_data = 32'h0; pixel_ready = 1'b0; res_data = 32'h0; res_valid = 1'b0;
    #1;
    test_reset();
    test_ctrl();
    test_pixel();
    test_fifo();
    test_irq_threshold();
    test_overflow();
    test_scratch_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected end before 200000", $time);
    $fatal(1);
  end

endmodule
